// File: rtl/oh_latfifo.sv
// oh_latfifo: single-clock FIFO, latch-array storage, flop pointers/staging/output.
// Ports: clk, nreset | wr_en, wr_din, wr_full | rd_en, rd_dout, rd_valid, rd_empty | count, wr_overflow, rd_underflow.

// asic_latnq: 1-bit latch, transparent while clk is low.
module asic_latnq #(
  parameter PROP = "DEFAULT"
) (
  input  logic d,
  input  logic clk,
  output logic q
);

  // Target libraries map PROP to a cell; both arms share the same behaviour.
  if (PROP == "DEFAULT") begin : g_def
    always_latch begin
      if (!clk) q <= d;
    end
  end else begin : g_lib
    always_latch begin
      if (!clk) q <= d;
    end
  end

endmodule

module oh_latfifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter     PROP  = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_din,
  output logic          wr_full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dout,
  output logic          rd_valid,
  output logic          rd_empty,
  output logic [AW:0]   count,
  output logic          wr_overflow,
  output logic          rd_underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_pending_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          valid_q;
  logic [DW-1:0] dout_q;
  logic          ovf_q, udf_q;

  logic          wr_go, rd_go;
  logic [DEPTH-1:0] row_clk;
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    wr_go    = wr_en & ~full_q;
    rd_go    = rd_en & ~empty_q;
    wr_ptr_d = wr_go ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_go ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_go) - (AW+1)'(rd_go);
  end

  // Row clock is held high except in the low phase after an accepting
  // edge; enables come from flops, so they only move while clk is high.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic [DW-1:0] row_q;
    assign row_clk[i] = clk | ~(wr_pending_q & (wr_addr_q == AW'(i)));
    for (genvar j = 0; j < DW; j++) begin : g_bit
      asic_latnq #(.PROP(PROP)) u_lat (
        .d   (wr_data_q[j]),
        .clk (row_clk[i]),
        .q   (row_q[j])
      );
    end
    assign mem[i] = row_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_pending_q <= 1'b0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
      dout_q       <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_pending_q <= wr_go;
      if (wr_go) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= wr_din;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == (AW+1)'(DEPTH));
      valid_q <= rd_go;
      if (rd_go) dout_q <= mem[rd_ptr_q];
      if (wr_en & full_q)  ovf_q <= 1'b1;
      if (rd_en & empty_q) udf_q <= 1'b1;
    end
  end

  assign wr_full      = full_q;
  assign rd_empty     = empty_q;
  assign count        = count_q;
  assign rd_valid     = valid_q;
  assign rd_dout      = dout_q;
  assign wr_overflow  = ovf_q;
  assign rd_underflow = udf_q;

endmodule
